// File: rtl/sprite_pkg.sv
// Shared types and default maze contents for the sprite motion engine.
// Tables are packed arrays of rect_t so a different maze can be supplied as a parameter.
package sprite_pkg;

  localparam int TAB_W          = 10;
  localparam int N_WALLS_DEF    = 8;
  localparam int N_COOKIES_DEF  = 8;
  localparam int COOKIE_SZ      = 6;

  typedef enum logic [2:0] {NONE, UP, RIGHT, LEFT, DOWN} dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUND,
    S_WALL,
    S_COOKIE,
    S_COMMIT
  } state_t;

  typedef struct packed {
    logic [TAB_W-1:0] x0;
    logic [TAB_W-1:0] y0;
    logic [TAB_W-1:0] x1;
    logic [TAB_W-1:0] y1;
  } rect_t;

  typedef rect_t [N_WALLS_DEF-1:0]   wall_tab_t;
  typedef rect_t [N_COOKIES_DEF-1:0] cookie_tab_t;

  function automatic rect_t mk_rect(input int x0, input int y0, input int x1, input int y1);
    rect_t r;
    r.x0 = TAB_W'(x0);
    r.y0 = TAB_W'(y0);
    r.x1 = TAB_W'(x1);
    r.y1 = TAB_W'(y1);
    return r;
  endfunction

  function automatic rect_t mk_cookie(input int ox, input int oy);
    return mk_rect(ox, oy, ox + COOKIE_SZ - 1, oy + COOKIE_SZ - 1);
  endfunction

  // Index 0 is the rightmost entry. The spare slot has x0>x1, so it can never overlap.
  localparam wall_tab_t DEF_WALLS = {
    mk_rect(1, 1, 0, 0),
    mk_rect(500, 160, 520, 280),
    mk_rect(180, 160, 200, 280),
    mk_rect(440, 350, 540, 370),
    mk_rect(110, 350, 210, 370),
    mk_rect(440, 110, 540, 130),
    mk_rect(110, 110, 210, 130),
    mk_rect(260, 240, 400, 260)
  };

  localparam cookie_tab_t DEF_COOKIES = {
    mk_cookie(490, 385),
    mk_cookie(160, 385),
    mk_cookie(320, 320),
    mk_cookie(320, 120),
    mk_cookie(560, 220),
    mk_cookie(140, 220),
    mk_cookie(480, 80),
    mk_cookie(90, 80)
  };

endpackage

// File: rtl/sprite_motion_engine_maze_rom.sv
// Combinational maze lookup: one wall rectangle and one cookie square per index.
module maze_rom
  import sprite_pkg::*;
#(
  parameter int N_WALLS   = N_WALLS_DEF,
  parameter int N_COOKIES = N_COOKIES_DEF,
  parameter int WI_W      = (N_WALLS > 1) ? $clog2(N_WALLS) : 1,
  parameter int CI_W      = (N_COOKIES > 1) ? $clog2(N_COOKIES) : 1,
  parameter rect_t [N_WALLS-1:0]   WALL_TAB   = DEF_WALLS,
  parameter rect_t [N_COOKIES-1:0] COOKIE_TAB = DEF_COOKIES
) (
  input  logic [WI_W-1:0] i_wall_idx,
  input  logic [CI_W-1:0] i_cookie_idx,
  output rect_t           o_wall,
  output rect_t           o_cookie
);

  assign o_wall   = WALL_TAB[i_wall_idx];
  assign o_cookie = COOKIE_TAB[i_cookie_idx];

endmodule

// File: rtl/sprite_motion_engine.sv
// Single-sprite mover: each accepted tick scans bounds, walls and cookies for the
// candidate box, then commits the step unless something blocked it.
module sprite_motion_engine
  import sprite_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int SPR_W     = 20,
  parameter int SPR_H     = 20,
  parameter int VEL       = 2,
  parameter int N_WALLS   = N_WALLS_DEF,
  parameter int N_COOKIES = N_COOKIES_DEF,
  parameter int SCORE_W   = 4,
  parameter int X_INIT    = 330,
  parameter int Y_INIT    = 180,
  parameter int X_MIN     = 70,
  parameter int X_MAX     = 599,
  parameter int Y_MIN     = 70,
  parameter int Y_MAX     = 429,
  parameter rect_t [N_WALLS-1:0]   WALL_TAB   = DEF_WALLS,
  parameter rect_t [N_COOKIES-1:0] COOKIE_TAB = DEF_COOKIES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  output logic [COORD_W-1:0]   x_pos,
  output logic [COORD_W-1:0]   y_pos,
  output logic [N_COOKIES-1:0] eaten,
  output logic [SCORE_W-1:0]   score,
  output logic                 all_eaten,
  output logic                 busy,
  output logic                 blocked
);

  localparam int CW1    = COORD_W + 1;
  localparam int EW     = COORD_W + 2;
  localparam int SCAN_N = (N_WALLS > N_COOKIES) ? N_WALLS : N_COOKIES;
  localparam int IDX_W  = (SCAN_N > 1) ? $clog2(SCAN_N) : 1;
  localparam int WI_W   = (N_WALLS > 1) ? $clog2(N_WALLS) : 1;
  localparam int CI_W   = (N_COOKIES > 1) ? $clog2(N_COOKIES) : 1;

  typedef logic [EW-1:0] ext_t;

  state_t               r_state;
  state_t               w_next;
  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic [CW1-1:0]       r_cx;
  logic [CW1-1:0]       r_cy;
  logic                 r_blk;
  logic                 r_blocked;
  logic [N_COOKIES-1:0] r_eaten;
  logic [SCORE_W-1:0]   r_score;
  logic [IDX_W-1:0]     r_idx;

  dir_t                 w_dir;
  logic                 w_accept;
  logic                 w_last_wall;
  logic                 w_last_cookie;
  logic [CW1-1:0]       w_cx;
  logic [CW1-1:0]       w_cy;
  ext_t                 w_bx0;
  ext_t                 w_bx1;
  ext_t                 w_by0;
  ext_t                 w_by1;
  rect_t                w_wall;
  rect_t                w_cookie;
  logic [WI_W-1:0]      w_widx;
  logic [CI_W-1:0]      w_cidx;
  logic                 w_bound_blk;
  logic                 w_wall_hit;
  logic                 w_cookie_hit;

  function automatic logic overlaps(input ext_t ax0, input ext_t ax1, input ext_t ay0,
                                    input ext_t ay1, input rect_t r);
    return (ax0 <= ext_t'(r.x1)) && (ext_t'(r.x0) <= ax1) &&
           (ay0 <= ext_t'(r.y1)) && (ext_t'(r.y0) <= ay1);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_dir = NONE;
    if (up)         w_dir = UP;
    else if (right) w_dir = RIGHT;
    else if (left)  w_dir = LEFT;
    else if (down)  w_dir = DOWN;
  end

  assign w_accept = (r_state == S_IDLE) && tick && (w_dir != NONE);

  // One extra bit lets a step below zero show up as a set MSB instead of wrapping.
  always_comb begin
    w_cx = {1'b0, r_x};
    w_cy = {1'b0, r_y};
    case (w_dir)
      UP:      w_cy = {1'b0, r_y} - CW1'(VEL);
      DOWN:    w_cy = {1'b0, r_y} + CW1'(VEL);
      LEFT:    w_cx = {1'b0, r_x} - CW1'(VEL);
      RIGHT:   w_cx = {1'b0, r_x} + CW1'(VEL);
      default: ;
    endcase
  end

  assign w_bx0 = ext_t'(r_cx);
  assign w_bx1 = ext_t'(r_cx) + ext_t'(SPR_W - 1);
  assign w_by0 = ext_t'(r_cy);
  assign w_by1 = ext_t'(r_cy) + ext_t'(SPR_H - 1);

  assign w_bound_blk = r_cx[COORD_W] | r_cy[COORD_W] |
                       (w_bx0 < ext_t'(X_MIN)) | (w_bx1 > ext_t'(X_MAX)) |
                       (w_by0 < ext_t'(Y_MIN)) | (w_by1 > ext_t'(Y_MAX));

  assign w_widx        = r_idx[WI_W-1:0];
  assign w_cidx        = r_idx[CI_W-1:0];
  assign w_last_wall   = (r_idx == IDX_W'(N_WALLS - 1));
  assign w_last_cookie = (r_idx == IDX_W'(N_COOKIES - 1));

  maze_rom #(
    .N_WALLS    (N_WALLS),
    .N_COOKIES  (N_COOKIES),
    .WI_W       (WI_W),
    .CI_W       (CI_W),
    .WALL_TAB   (WALL_TAB),
    .COOKIE_TAB (COOKIE_TAB)
  ) u_maze_rom (
    .i_wall_idx   (w_widx),
    .i_cookie_idx (w_cidx),
    .o_wall       (w_wall),
    .o_cookie     (w_cookie)
  );

  assign w_wall_hit   = overlaps(w_bx0, w_bx1, w_by0, w_by1, w_wall);
  assign w_cookie_hit = overlaps(w_bx0, w_bx1, w_by0, w_by1, w_cookie);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_BOUND;
      S_BOUND:  w_next = S_WALL;
      S_WALL:   if (w_last_wall) w_next = S_COOKIE;
      S_COOKIE: if (w_last_cookie) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x       <= COORD_W'(X_INIT);
      r_y       <= COORD_W'(Y_INIT);
      r_cx      <= '0;
      r_cy      <= '0;
      r_blk     <= 1'b0;
      r_blocked <= 1'b0;
      r_eaten   <= '0;
      r_score   <= '0;
      r_idx     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cx  <= w_cx;
            r_cy  <= w_cy;
            r_blk <= 1'b0;
            r_idx <= '0;
          end
        end
        S_BOUND: r_blk <= w_bound_blk;
        S_WALL: begin
          r_blk <= r_blk | w_wall_hit;
          r_idx <= w_last_wall ? '0 : r_idx + IDX_W'(1);
        end
        S_COOKIE: begin
          if (!r_blk && !r_eaten[w_cidx] && w_cookie_hit) begin
            r_eaten[w_cidx] <= 1'b1;
            if (r_score != '1) r_score <= r_score + SCORE_W'(1);
          end
          r_idx <= w_last_cookie ? '0 : r_idx + IDX_W'(1);
        end
        S_COMMIT: begin
          if (!r_blk) begin
            r_x <= r_cx[COORD_W-1:0];
            r_y <= r_cy[COORD_W-1:0];
          end
          r_blocked <= r_blk;
        end
        default: ;
      endcase
    end
  end

  // busy also covers the accepting cycle so the source sees the tick was consumed.
  assign busy      = (r_state != S_IDLE) | w_accept;
  assign x_pos     = r_x;
  assign y_pos     = r_y;
  assign eaten     = r_eaten;
  assign score     = r_score;
  assign all_eaten = &r_eaten;
  assign blocked   = r_blocked;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Bench for sprite_motion_engine: default maze instance plus a 16-cookie instance for score saturation.
module tb_sprite_motion_engine;
  import sprite_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tick, up, down, left, right;
  logic [9:0] x_pos, y_pos;
  logic [7:0] eaten;
  logic [3:0] score;
  logic all_eaten, busy, blocked;

  logic tick2, up2, down2, left2, right2;
  logic [9:0] x2, y2;
  logic [15:0] eaten2;
  logic [3:0] score2;
  logic all_eaten2, busy2, blocked2;

  localparam rect_t CK = '{x0: 10'd335, y0: 10'd185, x1: 10'd340, y1: 10'd190};

  sprite_motion_engine dut (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .down(down), .left(left), .right(right),
    .x_pos(x_pos), .y_pos(y_pos), .eaten(eaten), .score(score),
    .all_eaten(all_eaten), .busy(busy), .blocked(blocked)
  );

  sprite_motion_engine #(.N_COOKIES(16), .COOKIE_TAB({16{CK}})) dut2 (
    .clk(clk), .rst(rst), .tick(tick2), .up(up2), .down(down2), .left(left2), .right(right2),
    .x_pos(x2), .y_pos(y2), .eaten(eaten2), .score(score2),
    .all_eaten(all_eaten2), .busy(busy2), .blocked(blocked2)
  );

  typedef struct {
    logic [3:0] btn;   // {up, right, left, down}
    int x;
    int y;
    int blk;
    int score;
    int eaten;
    int lat;
  } vec_t;

  int   n_checks = 0;
  int   n_bad    = 0;
  vec_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] btn, input int x, input int y, input int blk,
                              input int sc, input int ea, input int lat);
    vec_t v;
    v.btn = btn; v.x = x; v.y = y; v.blk = blk; v.score = sc; v.eaten = ea; v.lat = lat;
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One move on either instance; the expectation is queued first and popped once busy drops.
  task automatic move(input bit sel, input vec_t v, input string tag);
    vec_t e;
    int lat;
    exp_q.push_back(v);
    @(negedge clk);
    if (sel) begin {up2, right2, left2, down2} = v.btn; tick2 = 1'b1; end
    else     begin {up, right, left, down} = v.btn;     tick  = 1'b1; end
    #1;
    lat = (sel ? busy2 : busy) ? 1 : 0;
    @(posedge clk); #1;
    tick = 1'b0; {up, right, left, down} = 4'b0;
    tick2 = 1'b0; {up2, right2, left2, down2} = 4'b0;
    while ((sel ? busy2 : busy) && lat < 100) begin
      lat++;
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    check({tag, ".lat"}, lat, e.lat);
    check({tag, ".x"}, sel ? int'(x2) : int'(x_pos), e.x);
    check({tag, ".y"}, sel ? int'(y2) : int'(y_pos), e.y);
    check({tag, ".blocked"}, sel ? int'(blocked2) : int'(blocked), e.blk);
    check({tag, ".score"}, sel ? int'(score2) : int'(score), e.score);
    check({tag, ".eaten"}, sel ? int'(eaten2) : int'(eaten), e.eaten);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int n;
    bit saw;

    rst = 1'b1; tick = 0; up = 0; down = 0; left = 0; right = 0;
    tick2 = 0; up2 = 0; down2 = 0; left2 = 0; right2 = 0;

    tbl[0] = mk(4'b1000, 330, 178, 0, 0, 0, 19);
    tbl[1] = mk(4'b1001, 330, 176, 0, 0, 0, 19);
    tbl[2] = mk(4'b0110, 332, 176, 0, 0, 0, 19);
    tbl[3] = mk(4'b0011, 330, 176, 0, 0, 0, 19);
    tbl[4] = mk(4'b0001, 330, 178, 0, 0, 0, 19);
    tbl[5] = mk(4'b1111, 330, 176, 0, 0, 0, 19);
    tbl[6] = mk(4'b0101, 332, 176, 0, 0, 0, 19);
    tbl[7] = mk(4'b0000, 332, 176, 0, 0, 0, 0);

    apply_reset();
    check("reset.x", int'(x_pos), 330);
    check("reset.y", int'(y_pos), 180);
    check("reset.score", int'(score), 0);
    check("reset.eaten", int'(eaten), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.blocked", int'(blocked), 0);
    check("reset.all_eaten", int'(all_eaten), 0);
    check("reset2.score", int'(score2), 0);

    // Saturation: 16 stacked cookies eaten in one scan, score pinned at 15.
    move(1'b1, mk(4'b1000, 330, 178, 0, 15, 16'hFFFF, 27), "sat.up");
    check("sat.all_eaten", int'(all_eaten2), 1);
    move(1'b1, mk(4'b0001, 330, 180, 0, 15, 16'hFFFF, 27), "sat.down");

    // Latency and direction priority from the reset position.
    for (int i = 0; i < 8; i++) move(1'b0, tbl[i], $sformatf("tbl%0d", i));

    // A tick arriving mid-scan is dropped, not queued.
    @(negedge clk); up = 1'b1; tick = 1'b1;
    @(negedge clk); up = 1'b0; tick = 1'b0;
    repeat (3) @(negedge clk);
    down = 1'b1; tick = 1'b1;
    @(negedge clk); down = 1'b0; tick = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    check("ignore.y", int'(y_pos), 174);
    saw = 1'b0;
    repeat (25) begin @(negedge clk); if (busy) saw = 1'b1; end
    check("ignore.no_second_scan", int'(saw), 0);
    check("ignore.y_hold", int'(y_pos), 174);
    check("ignore.x", int'(x_pos), 332);

    // Down into the centre bar.
    apply_reset();
    for (int k = 1; k <= 20; k++)
      move(1'b0, mk(4'b0001, 330, 180 + 2 * k, 0, 0, 0, 19), $sformatf("wall%0d", k));
    move(1'b0, mk(4'b0001, 330, 220, 1, 0, 0, 19), "wall.blk");
    move(1'b0, mk(4'b1000, 330, 218, 0, 0, 0, 19), "wall.clear");

    // Cookie 4 at (320,120), then a revisit.
    apply_reset();
    for (int k = 1; k <= 3; k++)
      move(1'b0, mk(4'b0010, 330 - 2 * k, 180, 0, 0, 0, 19), $sformatf("ck.left%0d", k));
    for (int k = 1; k <= 28; k++)
      move(1'b0, mk(4'b1000, 324, 180 - 2 * k, 0, (k == 28) ? 1 : 0, (k == 28) ? 16'h10 : 0, 19),
           $sformatf("ck.up%0d", k));
    move(1'b0, mk(4'b0001, 324, 126, 0, 1, 16'h10, 19), "ck.away");
    move(1'b0, mk(4'b1000, 324, 124, 0, 1, 16'h10, 19), "ck.revisit");

    // Top bound.
    apply_reset();
    for (int k = 1; k <= 55; k++)
      move(1'b0, mk(4'b1000, 330, 180 - 2 * k, 0, 0, 0, 19), $sformatf("bnd%0d", k));
    move(1'b0, mk(4'b1000, 330, 70, 1, 0, 0, 19), "bnd.blk");

    // Reset in the middle of the wall scan.
    @(negedge clk); left = 1'b1; tick = 1'b1;
    @(negedge clk); left = 1'b0; tick = 1'b0;
    repeat (4) @(negedge clk);
    check("mid.busy_before", int'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid.busy", int'(busy), 0);
    check("mid.x", int'(x_pos), 330);
    check("mid.y", int'(y_pos), 180);
    check("mid.blocked", int'(blocked), 0);
    repeat (30) @(negedge clk);
    check("mid.x_hold", int'(x_pos), 330);
    check("mid.y_hold", int'(y_pos), 180);
    check("mid.blocked_hold", int'(blocked), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
